// File: rtl/bcd_scan_pkg.sv
// Shared types, constants and width helper for the BCD scan controller.
package bcd_scan_pkg;

  // Controller phases: wait, capture inputs, run the shared converter, drive the display.
  typedef enum logic [1:0] {
    IDLE,
    SNAP,
    CONV,
    SCAN
  } state_e;

  // Wide enough for the largest legal display (8 channels -> 16 digits); slice to fit.
  localparam logic [15:0] ANODE_OFF = 16'hFFFF;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned log2ceil(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_scan_controller_dwell_timer.sv
// Free-running dwell counter: counts 0..PRESCALE-1 while enabled, ticks on the last count.
module dwell_timer
  import bcd_scan_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = log2ceil(PRESCALE);
  localparam logic [W-1:0] Last = W'(PRESCALE - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && !clr && (cnt_q == Last);

  // Next count: clear wins, then wrap at the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bcd_scan_controller.sv
// Shares one Binary2BCD converter across NUM_CH count sources and scans the buffered
// tens/ones digits onto a multiplexed common-anode seven-segment display.
module bcd_scan_controller
  import bcd_scan_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned PRESCALE = 50000
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Enable,
  input  logic [4*NUM_CH-1:0]   Cnt_in,
  output logic [3:0]            Bcd_cnt,
  input  logic [3:0]            Bcd_tens,
  input  logic [3:0]            Bcd_ones,
  output logic [2*NUM_CH-1:0]   Digit_sel,
  output logic [3:0]            Digit_val,
  output logic                  Digit_blank,
  output logic                  Frame_done
);

  localparam int unsigned NumDig = 2 * NUM_CH;
  localparam int unsigned CW     = log2ceil(NUM_CH);
  localparam int unsigned DW     = log2ceil(NumDig);
  localparam logic [CW-1:0] ChLast  = CW'(NUM_CH - 1);
  localparam logic [DW-1:0] DigLast = DW'(NumDig - 1);
  localparam logic [NumDig-1:0] AnodeOff = ANODE_OFF[NumDig-1:0];

  state_e        state_q, state_d;
  logic [CW-1:0] ch_idx_q, ch_idx_d;
  logic [DW-1:0] dig_idx_q, dig_idx_d;
  logic [3:0]    snap_q     [NUM_CH];
  logic [3:0]    buf_ones_q [NUM_CH];
  logic [3:0]    buf_tens_q [NUM_CH];
  logic          snap_we, conv_we;
  logic          tick;
  logic [CW-1:0] dig_ch;
  logic          dig_odd;

  dwell_timer #(
    .PRESCALE(PRESCALE)
  ) u_dwell_timer (
    .clk (Clk),
    .rst (Rst),
    .clr (state_q != SCAN),
    .en  (state_q == SCAN),
    .tick(tick)
  );

  // Sequencing: snapshot, one converter pass per channel, then dwell on each digit.
  always_comb begin
    state_d    = state_q;
    ch_idx_d   = ch_idx_q;
    dig_idx_d  = dig_idx_q;
    snap_we    = 1'b0;
    conv_we    = 1'b0;
    Bcd_cnt    = 4'd0;
    Frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Enable) state_d = SNAP;
      end
      SNAP: begin
        snap_we  = 1'b1;
        ch_idx_d = '0;
        state_d  = CONV;
      end
      CONV: begin
        Bcd_cnt = snap_q[ch_idx_q];
        conv_we = 1'b1;
        if (ch_idx_q == ChLast) begin
          ch_idx_d  = '0;
          dig_idx_d = '0;
          state_d   = SCAN;
        end else begin
          ch_idx_d = ch_idx_q + 1'b1;
        end
      end
      SCAN: begin
        if (tick) begin
          if (dig_idx_q == DigLast) begin
            Frame_done = 1'b1;
            dig_idx_d  = '0;
            state_d    = SNAP;
          end else begin
            dig_idx_d = dig_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Dropping Enable abandons whatever frame is in flight.
    if (!Enable && state_q != IDLE) state_d = IDLE;
  end

  // FSM state and indices.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      ch_idx_q  <= '0;
      dig_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      ch_idx_q  <= ch_idx_d;
      dig_idx_q <= dig_idx_d;
    end
  end

  // Snapshot of the count inputs and the converted digit buffers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        snap_q[k]     <= 4'd0;
        buf_ones_q[k] <= 4'd0;
        buf_tens_q[k] <= 4'd0;
      end
    end else begin
      if (snap_we) begin
        for (int k = 0; k < NUM_CH; k++) begin
          snap_q[k] <= Cnt_in[4*k +: 4];
        end
      end
      if (conv_we) begin
        buf_ones_q[ch_idx_q] <= Bcd_ones;
        buf_tens_q[ch_idx_q] <= Bcd_tens;
      end
    end
  end

  assign dig_ch  = CW'(dig_idx_q >> 1);
  assign dig_odd = dig_idx_q[0];

  // Display decode from registered state only, so the anodes never glitch.
  always_comb begin
    Digit_sel   = AnodeOff;
    Digit_val   = 4'd0;
    Digit_blank = 1'b0;
    if (state_q == SCAN) begin
      Digit_val   = dig_odd ? buf_tens_q[dig_ch] : buf_ones_q[dig_ch];
      Digit_blank = dig_odd && (buf_tens_q[dig_ch] == 4'd0);
      if (!Digit_blank) Digit_sel[dig_idx_q] = 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_scan_controller.sv
// Self-checking bench for bcd_scan_controller with NUM_CH=2, PRESCALE=4.
module tb_bcd_scan_controller;

  localparam int unsigned NCh = 2;
  localparam int unsigned Pre = 4;
  localparam int FrameLen = 1 + NCh + 2 * NCh * Pre;
  // {sel[3:0], val[3:0], blank, frame_done, bcd_cnt[3:0]} while idle or in SNAP.
  localparam logic [13:0] IdleOut = {4'hF, 10'h000};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] cnt_in = 8'h00;
  logic [3:0] bcd_cnt, bcd_tens, bcd_ones;
  logic [3:0] digit_sel;
  logic [3:0] digit_val;
  logic       digit_blank, frame_done;
  logic [13:0] obs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Binary-to-BCD converter for values 0..15.
  assign bcd_tens = (bcd_cnt >= 4'd10) ? 4'd1 : 4'd0;
  assign bcd_ones = (bcd_cnt >= 4'd10) ? bcd_cnt - 4'd10 : bcd_cnt;

  assign obs = {digit_sel, digit_val, digit_blank, frame_done, bcd_cnt};

  bcd_scan_controller #(
    .NUM_CH  (NCh),
    .PRESCALE(Pre)
  ) dut (
    .Clk        (clk),
    .Rst        (rst),
    .Enable     (en),
    .Cnt_in     (cnt_in),
    .Bcd_cnt    (bcd_cnt),
    .Bcd_tens   (bcd_tens),
    .Bcd_ones   (bcd_ones),
    .Digit_sel  (digit_sel),
    .Digit_val  (digit_val),
    .Digit_blank(digit_blank),
    .Frame_done (frame_done)
  );

  // Expected outputs at cycle t of a frame (t=0 is SNAP) for a given snapshot.
  function automatic logic [13:0] model_out(input int t, input logic [7:0] snap);
    int s, d, c, shown;
    logic blank, fd;
    logic [3:0] sel;
    if (t == 0) return IdleOut;
    if (t <= NCh) begin
      c = int'(snap >> (4 * (t - 1))) & 15;
      return {4'hF, 4'h0, 1'b0, 1'b0, 4'(c)};
    end
    s     = t - NCh - 1;
    d     = s / Pre;
    c     = int'(snap >> (4 * (d / 2))) & 15;
    shown = (d % 2 == 1) ? c / 10 : c % 10;
    blank = (d % 2 == 1) && (c / 10 == 0);
    sel   = blank ? 4'hF : ~(4'(1) << d);
    fd    = (s == 2 * NCh * Pre - 1);
    return {sel, 4'(shown), blank, fd, 4'h0};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    cnt_in = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (obs !== IdleOut) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs, IdleOut);
      end
    end
    rst = 1'b0;
    cnt_in = {4'd13, 4'd7};
  endtask

  task automatic test_frame();
    logic [13:0] exp_v;
    for (int t = 0; t < FrameLen; t++) begin
      cycle();
      exp_v = model_out(t, {4'd13, 4'd7});
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL frame t=%0d got=%h exp=%h", t, obs, exp_v);
      end
    end
  endtask

  task automatic test_coherency();
    logic [13:0] exp_v;
    for (int t = 0; t < FrameLen; t++) begin
      cycle();
      exp_v = model_out(t, {4'd13, 4'd7});
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL coherency_old t=%0d got=%h exp=%h", t, obs, exp_v);
      end
      if (t == NCh + 1 + Pre) cnt_in = {4'd15, 4'd0};
    end
    for (int t = 0; t < FrameLen; t++) begin
      cycle();
      exp_v = model_out(t, {4'd15, 4'd0});
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL coherency_new t=%0d got=%h exp=%h", t, obs, exp_v);
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [13:0] exp_v;
    logic [7:0]  snap;
    for (int t = 0; t <= NCh + 1 + 2 * Pre; t++) begin
      cycle();
      exp_v = model_out(t, {4'd15, 4'd0});
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL drop_pre t=%0d got=%h exp=%h", t, obs, exp_v);
      end
    end
    en = 1'b0;
    cnt_in = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (obs !== IdleOut) begin
        bad++;
        $display("FAIL drop_idle cyc=%0d got=%h exp=%h", i, obs, IdleOut);
      end
    end
    en = 1'b1;
    for (int t = 0; t < FrameLen; t++) begin
      cycle();
      if (t == 0) begin
        snap = 8'($urandom);
        cnt_in = snap;
      end
      exp_v = model_out(t, snap);
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL drop_restart t=%0d got=%h exp=%h", t, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_conv();
    logic [13:0] exp_v;
    logic [7:0]  snap;
    snap = 8'($urandom);
    for (int t = 0; t <= NCh; t++) begin
      cycle();
      if (t == 0) cnt_in = snap;
      exp_v = model_out(t, snap);
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL rstconv_pre t=%0d got=%h exp=%h", t, obs, exp_v);
      end
    end
    rst = 1'b1;
    cycle();
    total++;
    if (obs !== IdleOut) begin
      bad++;
      $display("FAIL rstconv_idle got=%h exp=%h", obs, IdleOut);
    end
    rst = 1'b0;
    snap = ~snap;
    cnt_in = snap;
    for (int t = 0; t < FrameLen; t++) begin
      cycle();
      exp_v = model_out(t, snap);
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL rstconv_restart t=%0d got=%h exp=%h", t, obs, exp_v);
      end
      if (t > 0) cnt_in = 8'($urandom);
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] exp_v;
    logic [7:0]  snap;
    snap = cnt_in;
    for (int f = 0; f < 5; f++) begin
      for (int t = 0; t < FrameLen; t++) begin
        cycle();
        if (t == 0) begin
          snap = 8'($urandom);
          cnt_in = snap;
        end else begin
          cnt_in = 8'($urandom);
        end
        exp_v = model_out(t, snap);
        total++;
        if (obs !== exp_v) begin
          bad++;
          $display("FAIL back_to_back f=%0d t=%0d got=%h exp=%h", f, t, obs, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_coherency();
    test_enable_drop();
    test_reset_mid_conv();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
